// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory responder.
// Size encodings and FSM state enum.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store replication, load extract/extend.
// Ports: size_i, lo_i (aligned addr[1:0]), uns_i, wdata_i, rword_i -> be_o, wrep_o, rdata_o.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wrep_o,
  output logic [31:0] rdata_o
);

  logic [31:0] w_sh;

  assign w_sh = rword_i >> {lo_i, 3'b000};

  always_comb begin
    be_o    = 4'b1111;
    wrep_o  = wdata_i;
    rdata_o = rword_i;
    unique case (1'b1)
      (size_i == SZ_BYTE): begin
        be_o    = 4'b0001 << lo_i;
        wrep_o  = {4{wdata_i[7:0]}};
        rdata_o = {{24{~uns_i & w_sh[7]}}, w_sh[7:0]};
      end
      (size_i == SZ_HALF): begin
        be_o    = 4'b0011 << lo_i;
        wrep_o  = {2{wdata_i[15:0]}};
        rdata_o = {{16{~uns_i & w_sh[15]}}, w_sh[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wrep_o  = wdata_i;
        rdata_o = rword_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: MEM-stage data-memory responder with wait states (DMEM_MISALIGN_ERR_EN).
// Ports: clk, rst_n, req_* (valid/ready request), rsp_* (valid/ready response).
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_wdata;
  logic        r_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_access;
  logic        w_we;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic        w_uns;
  logic [31:0] w_wdata;
  logic        w_mis;
  logic        w_err;
  logic [1:0]  w_lo;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rword;
  logic [3:0]  w_be;
  logic [31:0] w_wrep;
  logic [31:0] w_ext;

  assign w_accept = (r_state == ST_IDLE) & req_valid_i;

  // With zero wait states the access uses the live request,
  // otherwise the latched copy.
  assign w_access = rst_n &
    (((WAIT_CYCLES == 0) & w_accept) |
     ((r_state == ST_WAIT) & (r_cnt == 3'd0)));

  assign w_we    = (r_state == ST_IDLE) ? req_we_i       : r_we;
  assign w_addr  = (r_state == ST_IDLE) ? req_addr_i     : r_addr;
  assign w_size  = (r_state == ST_IDLE) ? req_size_i     : r_size;
  assign w_uns   = (r_state == ST_IDLE) ? req_unsigned_i : r_uns;
  assign w_wdata = (r_state == ST_IDLE) ? req_wdata_i    : r_wdata;

`ifdef DMEM_MISALIGN_ERR_EN
  assign w_mis = ((w_size == SZ_HALF) & w_addr[0]) |
                 ((w_size == SZ_WORD) & (|w_addr[1:0]));
`else
  assign w_mis = 1'b0;
`endif

  assign w_err = (|w_addr[31:AW+2]) | (w_size == SZ_RSVD) | w_mis;

  // Misaligned halves/words are aligned down to their natural boundary.
  always_comb begin
    w_lo = w_addr[1:0];
    unique case (1'b1)
      (w_size == SZ_HALF): w_lo = {w_addr[1], 1'b0};
      (w_size == SZ_WORD): w_lo = 2'b00;
      default:             w_lo = w_addr[1:0];
    endcase
  end

  assign w_idx   = w_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];

  dmem_lane_align u_align (
    .size_i  (w_size),
    .lo_i    (w_lo),
    .uns_i   (w_uns),
    .wdata_i (w_wdata),
    .rword_i (w_rword),
    .be_o    (w_be),
    .wrep_o  (w_wrep),
    .rdata_o (w_ext)
  );

  always_ff @(posedge clk) begin
    if (w_access && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_size      <= 2'd0;
      r_uns       <= 1'b0;
      r_wdata     <= 32'd0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_size  <= req_size_i;
            r_uns   <= req_unsigned_i;
            r_wdata <= req_wdata_i;
            r_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rdata     <= (w_we | w_err) ? 32'd0 : w_ext;
              r_err       <= w_err;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rdata     <= (w_we | w_err) ? 32'd0 : w_ext;
            r_err       <= w_err;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_ready     <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed + random check of dmem_resp against a byte-array model.
// Honours DMEM_MISALIGN_ERR_EN in the expected values.
module tb_dmem_resp;

  localparam int WC = 1;
  localparam int DW = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [4*DW];

  always #5 clk = ~clk;

  dmem_resp #(
    .DEPTH_WORDS (DW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: aligns down, applies stores, extends loads.
  function automatic void model(input logic we,
                                input logic [31:0] addr,
                                input logic [1:0] sz,
                                input logic uns,
                                input logic [31:0] wd,
                                output logic [31:0] rd,
                                output logic err);
    int n;
    int a;
    logic [31:0] v;
    rd  = 32'd0;
    n   = (sz == 2'b11) ? 1 : (1 << sz);
    err = (addr >= 32'(4*DW)) || (sz == 2'b11);
`ifdef DMEM_MISALIGN_ERR_EN
    if ((addr % n) != 0) err = 1'b1;
`endif
    if (err) return;
    a = int'(addr) - int'(addr % n);
    if (we) begin
      for (int i = 0; i < n; i++) mdl[a+i] = wd[8*i +: 8];
      return;
    end
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a+i];
    if (!uns && v[8*n-1])
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    rd = v;
  endfunction

  task automatic xact(input logic we,
                      input logic [31:0] addr,
                      input logic [1:0] sz,
                      input logic uns,
                      input logic [31:0] wd,
                      input int hold,
                      input string tag);
    logic [31:0] erd;
    logic        eerr;
    logic [31:0] held;
    int          lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = sz;
    req_uns   = uns;
    req_wdata = wd;
    #1;
    chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    model(we, addr, sz, uns, wd, erd, eerr);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_size  = 2'($urandom);
    req_uns   = 1'($urandom);
    req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(WC + 1));
    chk({tag, ".rdata"}, rsp_rdata, erd);
    chk({tag, ".err"}, 32'(rsp_err), 32'(eerr));
    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_v"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_d"}, rsp_rdata, held);
      chk({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, ".done_v"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".done_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_size  = 2'd0;
    req_uns   = 1'b0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.rdy", 32'(req_ready), 32'd1);
    chk("rst.v", 32'(rsp_valid), 32'd0);
    chk("rst.d", rsp_rdata, 32'd0);
    chk("rst.e", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++)
      xact(1'b1, 32'(4*w), 2'b10, 1'b0, $urandom, 0, "init");

    xact(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, "st_w");
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, "ld_w");
    chk("ld_w.val", rsp_rdata, 32'hDEADBEEF);

    xact(1'b1, 32'h10, 2'b10, 1'b0, 32'h0, 0, "clr");
    xact(1'b1, 32'h13, 2'b00, 1'b0, 32'h80, 0, "st_b");
    xact(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, "ld_bs");
    xact(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, "ld_bu");
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, "ld_bw");

    xact(1'b1, 32'h10, 2'b10, 1'b0, 32'h80011234, 0, "st_h");
    xact(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 0, "ld_hs");
    xact(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 0, "ld_hu");

    xact(1'b1, 32'h1000, 2'b10, 1'b0, 32'h12345678, 0, "st_oor");
    xact(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 0, "ld_0");
    xact(1'b1, 32'h4, 2'b11, 1'b0, 32'hFFFFFFFF, 0, "st_rsvd");
    xact(1'b0, 32'h4, 2'b11, 1'b0, 32'h0, 0, "ld_rsvd");
    xact(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 0, "ld_4");

    xact(1'b0, 32'h11, 2'b10, 1'b0, 32'h0, 0, "mis_w");
    xact(1'b0, 32'h13, 2'b01, 1'b0, 32'h0, 0, "mis_h");
    xact(1'b1, 32'h15, 2'b10, 1'b0, 32'hA5A5A5A5, 0, "mis_st");
    xact(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 0, "mis_chk");

    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5, "hold");

    // Reset during WAIT of a store: nothing may be written.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_size  = 2'b10;
    req_wdata = 32'h11111111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rstw.v", 32'(rsp_valid), 32'd0);
    chk("rstw.rdy", 32'(req_ready), 32'd1);
    chk("rstw.d", rsp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, "rstw.ld");

    for (int k = 0; k < 60; k++) begin
      a = 32'($urandom_range(0, 63));
      s = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) s = 2'b11;
      xact(1'($urandom), a, s, 1'($urandom), $urandom,
           $urandom_range(0, 2), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the five-stage RISC-V core: the target side of the MEM-stage load/store request interface whose read data is captured into the MEM/WB pipeline register. Accepts one request at a time over a valid/ready handshake, applies a configurable number of wait states, and performs byte-, half- or word-granular access into an internal word array. Loads are sign- or zero-extended before return; stores merge through byte enables.

## Interface
- DEPTH_WORDS, 1024: array size in 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 1: extra cycles between accept and array access; 0..7.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata_i  in  32  store data, right-justified (bits [7:0] for byte).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester takes response.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  request rejected (see Operation); valid only with rsp_valid_o.

## Operation
- FSM states IDLE, WAIT, RESP; reset state IDLE.
- IDLE: req_ready_o=1. On req_valid_i & req_ready_o, latch we/addr/size/unsigned/wdata; go WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else perform access and go RESP.
- WAIT: req_ready_o=0; counter decrements each cycle; at counter==0 perform access and go RESP.
- Access (single edge): compute error; if no error, store writes enabled bytes, load reads word and extracts lane addr[1:0]. Register rdata/err, set rsp_valid_o.
- RESP: rsp_valid_o=1, rsp_rdata_o/rsp_err_o stable; on rsp_ready_i go IDLE, rsp_valid_o=0 next cycle. No new request accepted in RESP.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Error if addr >= 4*DEPTH_WORDS or size==11; erroring stores do not modify the array.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Store data replicated across lanes before masking.
- Load extract: byte from lane addr[1:0], half from lanes addr[1:0] and +1; extend to 32 per req_unsigned_i.
- Array contents are not reset; reads of never-written words return X in simulation.

## Timing
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, state IDLE, counter 0.
- Latency: rsp_valid_o rises WAIT_CYCLES+1 cycles after the accept edge.
- Minimum request period WAIT_CYCLES+2 cycles (rsp_ready_i held high).
- Response held indefinitely while rsp_ready_i=0.
- rst_n asserted mid-WAIT or mid-RESP: transaction dropped, outputs to reset values immediately; a store whose access edge has not occurred is not written.
- req inputs ignored outside IDLE.

## Configuration
- DMEM_MISALIGN_ERR_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 sets rsp_err_o=1, rdata 0, no write.
- Not defined: misaligned addresses are silently aligned down (half clears addr[0], word clears addr[1:0]); no error raised.

## Structure
- Package dmem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum.
- One sub-module dmem_lane_align: combinational byte-enable/store-replicate and load extract/extend from size, addr[1:0], unsigned.
- Top holds FSM, counter, request latch, array, response registers.

## Test plan
- WAIT_CYCLES=1: store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_valid_o 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
- Store byte 0x80 @0x13 over 0x00000000, load signed byte @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80000000.
- Load half @0x12 after word 0x8001_1234 stored @0x10: signed -> 0xFFFF8001, unsigned -> 0x00008001.
- Addr 0x1000 with DEPTH_WORDS=1024, store then load @0x0: err 1 on store, word @0x0 unchanged; size 11 -> err 1.
- Misaligned word load @0x11: with DMEM_MISALIGN_ERR_EN err 1 rdata 0; without, returns word @0x10.
- rsp_ready_i low 5 cycles: rsp held stable, req_ready_o 0; rst_n pulse during WAIT of a store -> rsp_valid_o 0, req_ready_o 1, target word unchanged.
